// File: rtl/divider_unit_pkg.sv
// Shared types for the divide unit: request opcode, FSM states and counter width.
package divider_unit_pkg;

   localparam int DIV_CNT_W = 7;

   typedef enum logic {
      DIVOP = 1'b0,
      MODOP = 1'b1
   } divider_op_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, record the quotient bit.
module div_restoring_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // Trial subtraction; keep the shifted remainder when the divisor does not fit.
   always_comb begin
      shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
      diff     = shifted - {1'b0, divisor};
      fits     = (shifted >= {1'b0, divisor});
      rem_next = fits ? diff : shifted;
      quo_next = {quo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/divider_unit.sv
// Multi-cycle integer divide/remainder unit (DIV/DIVU/MOD/MODU and word forms).
// Operands are reduced to magnitudes at accept, divided one bit per cycle by a
// restoring step, and the sign/extension fixup is applied on entry to DONE.
// Divide-by-zero and signed overflow bypass the iteration and answer after one cycle.
module divider_unit
   import divider_unit_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int WORD_WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  divider_op_t       req_op,
   input  logic              req_signed,
   input  logic              req_word,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WIDTH-1:0]  resp_result
);

   localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MIN_WORD = {{(WIDTH-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};
   localparam logic [DIV_CNT_W-1:0] CNT_FULL = DIV_CNT_W'(WIDTH);
   localparam logic [DIV_CNT_W-1:0] CNT_WORD = DIV_CNT_W'(WORD_WIDTH);

   div_state_t             state;
   logic [DIV_CNT_W-1:0]   count;
   divider_op_t            op_q;
   logic                   word_q;
   logic                   neg_q;
   logic                   neg_r;
   logic [WIDTH:0]         rem_q;
   logic [WIDTH-1:0]       quo_q;
   logic [WIDTH-1:0]       div_q;

   logic [WIDTH:0]         rem_nx;
   logic [WIDTH-1:0]       quo_nx;

   logic signed [WIDTH-1:0] a_ext;
   logic signed [WIDTH-1:0] b_ext;
   logic [WIDTH-1:0]        a_mag;
   logic [WIDTH-1:0]        b_mag;
   logic                    sign_a;
   logic                    sign_b;
   logic                    b_zero;
   logic                    ovf;

   // Bring an operand to full width: word ops keep the low half, sign- or zero-extended.
   function automatic logic signed [WIDTH-1:0] op_extend(input logic [WIDTH-1:0] v,
                                                         input logic is_word,
                                                         input logic is_signed);
      logic signed [WIDTH-1:0] r;
      if (!is_word)
         r = v;
      else if (is_signed)
         r = {{(WIDTH-WORD_WIDTH){v[WORD_WIDTH-1]}}, v[WORD_WIDTH-1:0]};
      else
         r = {{(WIDTH-WORD_WIDTH){1'b0}}, v[WORD_WIDTH-1:0]};
      return r;
   endfunction

   // Absolute value when the operand is known negative.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic is_neg);
      logic signed [WIDTH-1:0] r;
      r = is_neg ? -v : v;
      return r;
   endfunction

   // Final result: optional negation, then word results sign-extended from bit 31.
   function automatic logic [WIDTH-1:0] fixup(input logic [WIDTH-1:0] v,
                                              input logic is_neg,
                                              input logic is_word);
      logic [WIDTH-1:0] r;
      r = is_neg ? (~v + 1'b1) : v;
      if (is_word)
         r = {{(WIDTH-WORD_WIDTH){r[WORD_WIDTH-1]}}, r[WORD_WIDTH-1:0]};
      return r;
   endfunction

   // Operand preparation at the request boundary: extension, signs, magnitudes, special cases.
   always_comb begin
      a_ext  = op_extend(req_a, req_word, req_signed);
      b_ext  = op_extend(req_b, req_word, req_signed);
      sign_a = req_signed & a_ext[WIDTH-1];
      sign_b = req_signed & b_ext[WIDTH-1];
      a_mag  = magnitude(a_ext, sign_a);
      b_mag  = magnitude(b_ext, sign_b);
      b_zero = (b_ext == '0);
      ovf    = req_signed && (&b_ext) &&
               (a_ext == (req_word ? MIN_WORD : MIN_FULL));
   end

   div_restoring_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (div_q),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   // Control FSM with registered handshake outputs, iteration registers and result fixup.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= DIV_IDLE;
         count       <= '0;
         op_q        <= DIVOP;
         word_q      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         rem_q       <= '0;
         quo_q       <= '0;
         div_q       <= '0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_result <= '0;
      end else if (flush) begin
         state      <= DIV_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (req_valid) begin
                  state     <= DIV_BUSY;
                  req_ready <= 1'b0;
                  op_q      <= req_op;
                  word_q    <= req_word;
                  div_q     <= b_mag;
                  if (b_zero) begin
                     // Quotient all ones, remainder is the dividend; no iteration.
                     quo_q <= '1;
                     rem_q <= {1'b0, a_ext};
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     count <= '0;
                  end else if (ovf) begin
                     // Most-negative / -1: quotient is the dividend, remainder zero.
                     quo_q <= a_ext;
                     rem_q <= '0;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     count <= '0;
                  end else begin
                     // Word dividends are left-aligned so the step always consumes quo[MSB].
                     quo_q <= req_word ? {a_mag[WORD_WIDTH-1:0], {(WIDTH-WORD_WIDTH){1'b0}}}
                                       : a_mag;
                     rem_q <= '0;
                     neg_q <= req_signed & (sign_a ^ sign_b);
                     neg_r <= sign_a;
                     count <= req_word ? CNT_WORD : CNT_FULL;
                  end
               end
            end
            DIV_BUSY: begin
               if (count != '0) begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  count <= count - 1'b1;
               end else begin
                  state       <= DIV_DONE;
                  resp_valid  <= 1'b1;
                  resp_result <= fixup((op_q == DIVOP) ? quo_q : rem_q[WIDTH-1:0],
                                       (op_q == DIVOP) ? neg_q : neg_r,
                                       word_q);
               end
            end
            DIV_DONE: begin
               if (resp_ready) begin
                  state      <= DIV_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state      <= DIV_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: a driver issues requests and queues the
// expected result and arrival cycle; a monitor pops and compares on each response.
module tb_divider_unit;
   import divider_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   divider_op_t req_op;
   logic        req_signed;
   logic        req_word;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_result;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int op_id    = 0;

   logic [63:0] exp_res[$];
   int          exp_due[$];
   int          exp_id[$];

   divider_unit #(.WIDTH(64), .WORD_WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_signed  (req_signed),
      .req_word    (req_word),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // RISC-V divide semantics computed directly with language division.
   function automatic logic [63:0] ref_model(input bit is_mod, input bit sgn, input bit wd,
                                             input logic [63:0] a, input logic [63:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     q, r, res;
      if (wd) begin
         sa = longint'($signed(a[31:0]));
         sb = longint'($signed(b[31:0]));
         ua = {32'd0, a[31:0]};
         ub = {32'd0, b[31:0]};
      end else begin
         sa = a; sb = b; ua = a; ub = b;
      end
      if (sgn) begin
         if (sb == 0) begin
            q = '1; r = sa;
         end else if (!wd && sb == -1 && sa == 64'sh8000_0000_0000_0000) begin
            q = sa; r = '0;
         end else begin
            q = sa / sb; r = sa % sb;
         end
      end else begin
         if (ub == 0) begin
            q = '1; r = ua;
         end else begin
            q = ua / ub; r = ua % ub;
         end
      end
      res = is_mod ? r : q;
      if (wd) res = {{32{res[31]}}, res[31:0]};
      return res;
   endfunction

   function automatic int ref_latency(input bit sgn, input bit wd,
                                      input logic [63:0] a, input logic [63:0] b);
      bit zero, ovf;
      zero = wd ? (b[31:0] == 32'd0) : (b == 64'd0);
      ovf  = sgn && (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (zero || ovf) return 1;
      return wd ? 33 : 65;
   endfunction

   task automatic issue(input divider_op_t op, input bit sgn, input bit wd,
                        input logic [63:0] a, input logic [63:0] b, input bit exp_resp);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) check("req_ready_wait", {63'd0, req_ready}, 64'd1);
      req_op = op; req_signed = sgn; req_word = wd; req_a = a; req_b = b;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (exp_resp) begin
         exp_res.push_back(ref_model(op == MODOP, sgn, wd, a, b));
         exp_due.push_back(cyc + ref_latency(sgn, wd, a, b));
         exp_id.push_back(op_id);
      end
      op_id++;
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_res.size() != 0 || resp_valid) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) check("drain_timeout", 64'd1, 64'd0);
   endtask

   // Monitor: pops an expectation on each new response and checks hold/handshake behaviour.
   initial begin : monitor
      logic [63:0] held;
      bit v_prev, hs_prev;
      int id, due;
      held = '0; v_prev = 0; hs_prev = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            v_prev = 0; hs_prev = 0;
         end else begin
            if (hs_prev) begin
               check("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
               check("valid_low_after_hs", {63'd0, resp_valid}, 64'd0);
            end
            if (resp_valid && !v_prev) begin
               if (exp_res.size() == 0) begin
                  check("unexpected_resp", 64'd1, 64'd0);
               end else begin
                  id  = exp_id.pop_front();
                  due = exp_due.pop_front();
                  check($sformatf("result_op%0d", id), resp_result, exp_res.pop_front());
                  check($sformatf("cycle_op%0d", id), 64'(cyc), 64'(due));
               end
               held = resp_result;
            end else if (resp_valid) begin
               check("result_stable", resp_result, held);
            end
            hs_prev = resp_valid && resp_ready && !flush;
            v_prev  = resp_valid;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [63:0] a, b;
      int sel;
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      req_op = DIVOP; req_signed = 1'b0; req_word = 1'b0; req_a = '0; req_b = '0;
      #1;
      check("reset_req_ready", {63'd0, req_ready}, 64'd1);
      check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("reset_resp_result", resp_result, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Directed cases
      issue(DIVOP, 1, 0, -64'sd7, 64'd2, 1);
      issue(MODOP, 1, 0, -64'sd7, 64'd2, 1);
      issue(MODOP, 0, 0, 64'd7, 64'd0, 1);
      issue(DIVOP, 0, 0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1);
      issue(DIVOP, 1, 0, 64'h8000_0000_0000_0000, '1, 1);
      issue(MODOP, 1, 0, 64'h8000_0000_0000_0000, '1, 1);
      issue(DIVOP, 0, 1, 64'h1_0000_0010, 64'd4, 1);
      issue(DIVOP, 1, 1, 64'hFFFF_FFFF, 64'd1, 1);
      issue(DIVOP, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 1);
      issue(MODOP, 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd0, 1);
      issue(MODOP, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 1);
      drain();

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         a = {$urandom, $urandom};
         sel = $urandom_range(0, 5);
         case (sel)
            0: b = 64'd0;
            1: b = '1;
            2: b = 64'($signed($urandom_range(0, 30)) - 15);
            3: b = {$urandom, $urandom};
            4: b = {32'd0, $urandom};
            default: begin
               a = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
               b = '1;
            end
         endcase
         if ($urandom_range(0, 3) == 0) a = {56'd0, 8'($urandom)};
         issue(divider_op_t'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), a, b, 1);
      end
      drain();

      // Back-pressure: hold resp_ready low for five cycles in DONE
      resp_ready = 1'b0;
      issue(DIVOP, 0, 0, 64'd100, 64'd7, 1);
      for (int g = 0; g < 100 && !resp_valid; g++) @(negedge clk);
      check("stall_valid_seen", {63'd0, resp_valid}, 64'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_valid_held", {63'd0, resp_valid}, 64'd1);
         check("stall_req_ready", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      drain();

      // Flush at T+10 of a busy operation
      issue(DIVOP, 0, 0, 64'd1000, 64'd3, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_req_ready", {63'd0, req_ready}, 64'd1);
      check("flush_resp_valid", {63'd0, resp_valid}, 64'd0);
      repeat (80) @(negedge clk);
      check("flush_no_resp", {63'd0, resp_valid}, 64'd0);

      // Request together with flush is not accepted
      @(negedge clk);
      req_op = DIVOP; req_signed = 1'b0; req_word = 1'b0; req_a = 64'd50; req_b = 64'd5;
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0; flush = 1'b0;
      check("flush_req_not_accepted", {63'd0, req_ready}, 64'd1);
      repeat (80) @(negedge clk);
      check("flush_req_no_resp", {63'd0, resp_valid}, 64'd0);

      // Asynchronous reset in the middle of an operation
      issue(DIVOP, 1, 0, 64'd999, 64'd9, 0);
      repeat (20) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_req_ready", {63'd0, req_ready}, 64'd1);
      check("midreset_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("midreset_resp_result", resp_result, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (80) @(negedge clk);
      check("midreset_no_resp", {63'd0, resp_valid}, 64'd0);

      // Unit still works after reset
      issue(MODOP, 1, 0, 64'd17, -64'sd5, 1);
      drain();
      check("queue_empty", 64'(exp_res.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
